// File: rtl/risc_mem_responder.sv
// Fixed-latency word-memory responder for the instruction handler's memory request bus.
// Optional write protection of words [0, RO_LIMIT-1]: define MEM_RESP_WR_PROTECT_EN.
module risc_mem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned RO_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_sel,
  input  logic        i_mem_req_valid,
  input  logic        i_mem_rd_wr,
  input  logic [31:0] i_mem_rd_addr,
  input  logic [31:0] i_mem_wr_addr,
  input  logic [31:0] i_mem_wr_data,
  output logic [31:0] o_mem_rd_data,
  output logic        o_mem_ack,
  output logic        o_busy,
  output logic        o_err_oob,
  output logic        o_overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
`ifdef MEM_RESP_WR_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  req_t          r_cur, w_cur_nxt;
  req_t          r_pend, w_pend_nxt;
  logic          r_pend_vld, w_pend_vld_nxt;
  logic [31:0]   r_rd_data, w_rd_data_nxt;
  logic          r_ack, w_ack_nxt;
  logic          r_err, w_err_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_busy;
  logic          w_mem_we;
  logic          w_cap;
  req_t          w_cap_req;
  logic          w_oob;
  logic          w_prot;
  logic [AW-1:0] w_idx;

  logic [31:0] r_mem [DEPTH];

  assign w_cap          = i_mem_sel & i_mem_req_valid;
  assign w_cap_req.wr   = i_mem_rd_wr;
  assign w_cap_req.addr = i_mem_rd_wr ? i_mem_wr_addr : i_mem_rd_addr;
  assign w_cap_req.data = i_mem_wr_data;

  // Upper address bits only matter for the range check.
  assign w_oob  = (r_cur.addr >= 32'(DEPTH));
  assign w_prot = WP_EN && r_cur.wr && (r_cur.addr < 32'(RO_LIMIT));
  assign w_idx  = r_cur.addr[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cur      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_rd_data  <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur      <= w_cur_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_ovf      <= w_ovf_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Array is never cleared; a write lands only on the edge entering ACK.
  always_ff @(posedge clk) begin
    if (w_mem_we && !reset) r_mem[w_idx] <= r_cur.data;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cur_nxt      = r_cur;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    w_rd_data_nxt  = r_rd_data;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_ovf_nxt      = r_ovf;
    w_mem_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          w_cur_nxt   = w_cap_req;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_cap) begin
          if (r_pend_vld) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_pend_nxt     = w_cap_req;
            w_pend_vld_nxt = 1'b1;
          end
        end
        if (r_cnt == '0) begin
          w_state_nxt = S_ACK;
          w_ack_nxt   = 1'b1;
          if (w_oob) begin
            w_err_nxt = 1'b1;
            if (!r_cur.wr) w_rd_data_nxt = '0;
          end else if (r_cur.wr) begin
            if (w_prot) w_err_nxt = 1'b1;
            else        w_mem_we  = 1'b1;
          end else begin
            w_rd_data_nxt = r_mem[w_idx];
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_ACK: begin
        // Pending is promoted first; a fresh capture then refills the slot.
        if (r_pend_vld) begin
          w_cur_nxt      = r_pend;
          w_cnt_nxt      = CNT_INIT;
          w_state_nxt    = S_WAIT;
          w_pend_vld_nxt = w_cap;
          if (w_cap) w_pend_nxt = w_cap_req;
        end else if (w_cap) begin
          w_cur_nxt   = w_cap_req;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_rd_data = r_rd_data;
  assign o_mem_ack     = r_ack;
  assign o_busy        = r_busy;
  assign o_err_oob     = r_err;
  assign o_overflow    = r_ovf;

endmodule
